// File: rtl/iod_delay_line_ctrl_if.sv
// Command handshake between the training/register side and the IOD delay-line sequencer.
interface iod_delay_line_ctrl_if #(
  parameter int TAP_W = 7
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [TAP_W-1:0] CMD_COUNT;
  logic             DONE;
  logic             ERR;
  logic             BUSY;

  modport master (
    output CMD_VALID, CMD_OP, CMD_COUNT,
    input  CMD_READY, DONE, ERR, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_COUNT,
    output CMD_READY, DONE, ERR, BUSY
  );
endinterface

// File: rtl/iod_delay_line_ctrl.sv
// Sequences LOAD/INC/DEC commands into spaced DELAY_LINE_LOAD/MOVE/DIRECTION pulses
// for one PolarFire IOD output lane, tracking the tap and enforcing range limits.
module iod_delay_line_ctrl #(
  parameter int TAP_W    = 7,
  parameter int MAX_TAP  = 127,
  parameter int INIT_TAP = 1,
  parameter int STEP_GAP = 3
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  iod_delay_line_ctrl_if.slave cmd,
  output logic [TAP_W-1:0]     TAP_VALUE,
  output logic                 OOR_STICKY,
  input  logic                 CLR_OOR,
  output logic                 DELAY_LINE_LOAD,
  output logic                 DELAY_LINE_MOVE,
  output logic                 DELAY_LINE_DIRECTION,
  input  logic                 DELAY_LINE_OUT_OF_RANGE
);

  localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STEP_GAP - 1);
  localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_T   = TAP_W'(INIT_TAP);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_MOVE, S_GAP, S_FINISH
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [TAP_W-1:0] rem;
  logic [GAP_W-1:0] gap_cnt;
  logic             oor_meta;
  logic             oor_sync;

  logic at_limit;
  logic check_now;
  logic check_fail;
  logic limit_term;

  // op_q[1] marks INC/DEC; the range check sits in front of every MOVE decision.
  always_comb begin
    at_limit   = (op_q == OP_INC) ? (TAP_VALUE == MAX_T) : (TAP_VALUE == '0);
    check_now  = op_q[1] && (rem != '0) &&
                 ((state == S_SETUP) || ((state == S_GAP) && (gap_cnt == '0)));
    check_fail = at_limit || oor_sync;
    limit_term = check_now && at_limit;
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      oor_meta <= 1'b0;
      oor_sync <= 1'b0;
    end else begin
      oor_meta <= DELAY_LINE_OUT_OF_RANGE;
      oor_sync <= oor_meta;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      OOR_STICKY <= 1'b0;
    end else if (oor_sync || limit_term) begin
      OOR_STICKY <= 1'b1;
    end else if (CLR_OOR) begin
      OOR_STICKY <= 1'b0;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= S_IDLE;
      op_q                 <= OP_NOP;
      rem                  <= '0;
      gap_cnt              <= '0;
      TAP_VALUE            <= INIT_T;
      cmd.CMD_READY        <= 1'b0;
      cmd.DONE             <= 1'b0;
      cmd.ERR              <= 1'b0;
      cmd.BUSY             <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
    end else begin
      cmd.DONE        <= 1'b0;
      cmd.ERR         <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.CMD_VALID && cmd.CMD_READY) begin
            op_q          <= cmd.CMD_OP;
            rem           <= cmd.CMD_COUNT;
            cmd.CMD_READY <= 1'b0;
            cmd.BUSY      <= 1'b1;
            // Direction is set as SETUP begins so it is stable well before the first MOVE.
            if (cmd.CMD_OP == OP_INC) DELAY_LINE_DIRECTION <= 1'b1;
            else if (cmd.CMD_OP == OP_DEC) DELAY_LINE_DIRECTION <= 1'b0;
            state <= S_SETUP;
          end else begin
            cmd.CMD_READY <= 1'b1;
          end
        end
        S_SETUP: begin
          if (op_q == OP_LOAD) begin
            DELAY_LINE_LOAD <= 1'b1;
            state           <= S_LOAD;
          end else if (!op_q[1] || (rem == '0)) begin
            cmd.DONE <= 1'b1;
            state    <= S_FINISH;
          end else if (check_fail) begin
            cmd.DONE <= 1'b1;
            cmd.ERR  <= 1'b1;
            state    <= S_FINISH;
          end else begin
            DELAY_LINE_MOVE <= 1'b1;
            state           <= S_MOVE;
          end
        end
        S_LOAD: begin
          TAP_VALUE <= INIT_T;
          rem       <= '0;
          gap_cnt   <= GAP_LAST;
          state     <= S_GAP;
        end
        S_MOVE: begin
          TAP_VALUE <= DELAY_LINE_DIRECTION ? (TAP_VALUE + TAP_W'(1)) : (TAP_VALUE - TAP_W'(1));
          rem       <= rem - TAP_W'(1);
          gap_cnt   <= GAP_LAST;
          state     <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (rem == '0) begin
            cmd.DONE <= 1'b1;
            state    <= S_FINISH;
          end else if (check_fail) begin
            cmd.DONE <= 1'b1;
            cmd.ERR  <= 1'b1;
            state    <= S_FINISH;
          end else begin
            DELAY_LINE_MOVE <= 1'b1;
            state           <= S_MOVE;
          end
        end
        S_FINISH: begin
          cmd.BUSY      <= 1'b0;
          cmd.CMD_READY <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Directed bench for iod_delay_line_ctrl: LOAD/INC/DEC timing, range limits, OOR sticky, reset abort.
module tb_iod_delay_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_oor;
  logic       oor_in;
  logic [6:0] tap;
  logic       oor_sticky;
  logic       dl_load;
  logic       dl_move;
  logic       dl_dir;

  int checks = 0;
  int errors = 0;

  iod_delay_line_ctrl_if #(.TAP_W(7)) cmd_if ();

  iod_delay_line_ctrl #(
    .TAP_W(7), .MAX_TAP(127), .INIT_TAP(1), .STEP_GAP(3)
  ) dut (
    .FAB_CLK                 (clk),
    .ARST_N                  (rst_n),
    .cmd                     (cmd_if),
    .TAP_VALUE               (tap),
    .OOR_STICKY              (oor_sticky),
    .CLR_OOR                 (clr_oor),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE (oor_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command (acceptance cycle = 0) and observes until DONE or the cycle budget expires.
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] cnt, input int oor_at, input bit hold,
                         output int n_moves, output int n_loads, output int done_c, output logic err_o,
                         output int mv_first, output int gap_bad, output int load_c, output logic dir_c1);
    int prev;
    n_moves = 0; n_loads = 0; done_c = -1; err_o = 1'b0;
    mv_first = -1; gap_bad = 0; load_c = -1; prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.CMD_READY) break;
      tick();
    end
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_COUNT = cnt;
    tick();
    if (hold) begin
      cmd_if.CMD_OP    = 2'b10;
      cmd_if.CMD_COUNT = 7'd5;
    end else begin
      cmd_if.CMD_VALID = 1'b0;
    end
    dir_c1 = dl_dir;
    for (int c = 1; c < 200; c++) begin
      if (dl_move) begin
        n_moves++;
        if (n_moves == 1) mv_first = c;
        else if (c - prev != 4) gap_bad++;
        prev = c;
        if (oor_at != 0 && n_moves == oor_at) oor_in = 1'b1;
      end
      if (dl_load) begin
        n_loads++;
        load_c = c;
      end
      if (cmd_if.DONE) begin
        done_c = c;
        err_o  = cmd_if.ERR;
        cmd_if.CMD_VALID = 1'b0;
        break;
      end
      tick();
    end
  endtask

  int   nm, nl, dc, mf, gb, lc, seen_done, tap_before;
  logic er, d1;

  initial begin
    rst_n = 1'b0;
    clr_oor = 1'b0;
    oor_in = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP = 2'b00;
    cmd_if.CMD_COUNT = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_if.CMD_READY, 0);
    check("rst_busy", cmd_if.BUSY, 0);
    check("rst_done", cmd_if.DONE, 0);
    check("rst_tap", tap, 1);
    check("rst_dir", dl_dir, 0);
    check("rst_sticky", oor_sticky, 0);
    check("rst_pulses", {dl_move, dl_load}, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", cmd_if.CMD_READY, 1);

    // LOAD from reset
    run_cmd(2'b01, 7'd9, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("load_pulse_cyc", lc, 2);
    check("load_count", nl, 1);
    check("load_moves", nm, 0);
    check("load_done_cyc", dc, 6);
    check("load_err", er, 0);
    check("load_tap", tap, 1);
    check("load_busy_at_done", cmd_if.BUSY, 1);
    tick();
    check("ready_after_done", cmd_if.CMD_READY, 1);
    check("busy_after_done", cmd_if.BUSY, 0);

    // INC 5 from tap 1
    run_cmd(2'b10, 7'd5, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("inc5_dir_c1", d1, 1);
    check("inc5_first_move", mf, 2);
    check("inc5_moves", nm, 5);
    check("inc5_spacing", gb, 0);
    check("inc5_done_cyc", dc, 22);
    check("inc5_err", er, 0);
    check("inc5_tap", tap, 6);
    check("inc5_sticky", oor_sticky, 0);

    // LOAD keeps direction, restores tap; then INC 1 to reach tap 2
    run_cmd(2'b01, 7'd0, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("load2_tap", tap, 1);
    check("load2_dir_kept", dl_dir, 1);
    run_cmd(2'b10, 7'd1, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("inc1_done_cyc", dc, 6);
    check("inc1_tap", tap, 2);

    // DEC 4 from tap 2 hits zero after two steps
    run_cmd(2'b11, 7'd4, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("dec4_dir_c1", d1, 0);
    check("dec4_moves", nm, 2);
    check("dec4_done_cyc", dc, 10);
    check("dec4_err", er, 1);
    check("dec4_tap", tap, 0);
    check("dec4_sticky", oor_sticky, 1);
    clr_oor = 1'b1;
    tick();
    clr_oor = 1'b0;
    check("dec4_sticky_cleared", oor_sticky, 0);

    // INC 10 from tap 0 with IOD out-of-range raised after the third MOVE
    run_cmd(2'b10, 7'd10, 3, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("oor_moves_3_or_4", (nm >= 3 && nm <= 4) ? 1 : 0, 1);
    check("oor_done_cyc", dc, 2 + 4 * nm);
    check("oor_err", er, 1);
    check("oor_tap", tap, nm);
    check("oor_sticky", oor_sticky, 1);
    clr_oor = 1'b1;
    tick();
    tick();
    check("oor_set_beats_clr", oor_sticky, 1);
    clr_oor = 1'b0;
    oor_in = 1'b0;
    repeat (3) tick();
    clr_oor = 1'b1;
    tick();
    clr_oor = 1'b0;
    check("oor_sticky_cleared", oor_sticky, 0);

    // NOP with VALID held high carrying a different command during busy
    tap_before = int'(tap);
    run_cmd(2'b00, 7'd7, 0, 1, nm, nl, dc, er, mf, gb, lc, d1);
    check("nop_done_cyc", dc, 2);
    check("nop_pulses", nm + nl, 0);
    check("nop_err", er, 0);
    check("nop_tap", tap, tap_before);
    tick();
    check("nop_no_reaccept", cmd_if.BUSY, 0);

    // INC with COUNT=0
    run_cmd(2'b10, 7'd0, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("inc0_done_cyc", dc, 2);
    check("inc0_moves", nm, 0);
    check("inc0_tap", tap, tap_before);

    // Reset during the second MOVE of an INC 5
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.CMD_READY) break;
      tick();
    end
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = 2'b10;
    cmd_if.CMD_COUNT = 7'd5;
    tick();
    cmd_if.CMD_VALID = 1'b0;
    nm = 0;
    for (int i = 0; i < 40; i++) begin
      if (dl_move) begin
        nm++;
        if (nm == 2) break;
      end
      tick();
    end
    check("abort_reached_move2", nm, 2);
    rst_n = 1'b0;
    #1;
    check("abort_move", dl_move, 0);
    check("abort_busy", cmd_if.BUSY, 0);
    check("abort_tap", tap, 1);
    check("abort_ready", cmd_if.CMD_READY, 0);
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_if.DONE || dl_move) seen_done = 1;
    end
    rst_n = 1'b1;
    tick();
    if (cmd_if.DONE) seen_done = 1;
    check("abort_no_done", seen_done, 0);

    run_cmd(2'b10, 7'd2, 0, 0, nm, nl, dc, er, mf, gb, lc, d1);
    check("post_rst_moves", nm, 2);
    check("post_rst_done_cyc", dc, 10);
    check("post_rst_err", er, 0);
    check("post_rst_tap", tap, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
